// File: rtl/if_id.sv
// IF/ID pipeline register: latches fetch PC/instruction into decode with stall, bubble and flush handling.
// Optional saturating perf counters enabled by defining IF_ID_PERF_EN.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef CTRL_WIDTH
`define CTRL_WIDTH 6
`endif

module if_id #(
    parameter int                 ADDR_W   = `INST_ADDR_WIDTH,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0000,
    parameter int                 CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [`CTRL_WIDTH-1:0]  stall,
    input  logic                    flush,
    input  logic                    pc_enable,
    input  logic [ADDR_W-1:0]       if_pc,
    input  logic [INST_W-1:0]       if_inst,
    output logic [ADDR_W-1:0]       id_pc,
    output logic [INST_W-1:0]       id_inst,
    output logic                    id_valid
`ifdef IF_ID_PERF_EN
   ,output logic [CNT_W-1:0]        perf_inst,
    output logic [CNT_W-1:0]        perf_stall,
    output logic [CNT_W-1:0]        perf_bubble
`endif
);
    localparam int CW = `CTRL_WIDTH;
    localparam logic [CW-1:0] STALL_USED = CW'(3'b110);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    state_t r_state, w_state_nxt;
    logic   w_clear, w_hold, w_bubble, w_pass;
    logic   w_unused_stall;

    // Only the IF (bit1) and ID (bit2) stall lines matter to this stage.
    assign w_unused_stall = |(stall & ~STALL_USED);

    always_comb begin
        w_clear  = flush | ~pc_enable;
        w_hold   = 1'b0;
        w_bubble = 1'b0;
        w_pass   = 1'b0;
        if (!w_clear) begin
            if (stall[2])      w_hold   = 1'b1;
            else if (stall[1]) w_bubble = 1'b1;
            else               w_pass   = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush)           w_state_nxt = pc_enable ? RUN : IDLE;
        else if (!pc_enable) w_state_nxt = IDLE;
        else begin
            case (r_state)
                IDLE:    w_state_nxt = RUN;
                RUN:     if (stall[2])  w_state_nxt = HOLD;
                HOLD:    if (!stall[2]) w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc    <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (w_clear) begin
            id_pc    <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (w_bubble) begin
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (w_pass) begin
            id_pc    <= if_pc;
            id_inst  <= if_inst;
            id_valid <= 1'b1;
        end
    end

`ifdef IF_ID_PERF_EN
    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_inst   <= '0;
            perf_stall  <= '0;
            perf_bubble <= '0;
        end else begin
            if (w_pass && perf_inst != '1)                     perf_inst   <= perf_inst + 1'b1;
            if (r_state == HOLD && perf_stall != '1)           perf_stall  <= perf_stall + 1'b1;
            if ((flush || w_bubble) && perf_bubble != '1)      perf_bubble <= perf_bubble + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id.sv
// Self-checking bench for if_id: directed scenarios plus a random run against a behavioural model.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef CTRL_WIDTH
`define CTRL_WIDTH 6
`endif

module tb_if_id;
    localparam int AW = `INST_ADDR_WIDTH;
    localparam int SW = `CTRL_WIDTH;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] stall;
    logic          flush;
    logic          pc_enable;
    logic [AW-1:0] if_pc;
    logic [31:0]   if_inst;
    logic [AW-1:0] id_pc;
    logic [31:0]   id_inst;
    logic          id_valid;

    int total = 0;
    int bad   = 0;

    // Model: decode-side view and run state (0 idle, 1 run, 2 hold)
    logic [AW-1:0] m_pc;
    logic [31:0]   m_inst;
    logic          m_valid;
    int            m_st;

`ifdef IF_ID_PERF_EN
    logic [31:0] perf_inst, perf_stall, perf_bubble;
    logic [3:0]  p4_inst, p4_stall, p4_bubble;
    longint      m_pi, m_ps, m_pb;
    logic [AW-1:0] s_pc;
    logic [31:0]   s_inst;
    logic          s_valid;
`endif

    always #5 clk = ~clk;

    if_id dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .pc_enable(pc_enable),
        .if_pc(if_pc), .if_inst(if_inst), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
`ifdef IF_ID_PERF_EN
       ,.perf_inst(perf_inst), .perf_stall(perf_stall), .perf_bubble(perf_bubble)
`endif
    );

`ifdef IF_ID_PERF_EN
    if_id #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .pc_enable(pc_enable),
        .if_pc(if_pc), .if_inst(if_inst), .id_pc(s_pc), .id_inst(s_inst), .id_valid(s_valid),
        .perf_inst(p4_inst), .perf_stall(p4_stall), .perf_bubble(p4_bubble)
    );
`endif

    function automatic longint sat(longint v, longint lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    task automatic model_reset();
        m_pc = '0; m_inst = NOP; m_valid = 1'b0; m_st = 0;
`ifdef IF_ID_PERF_EN
        m_pi = 0; m_ps = 0; m_pb = 0;
`endif
    endtask

    // One clock: the model applies the spec's priority rules to the inputs present at the edge.
    task automatic tick();
        int old_st;
        @(posedge clk);
        old_st = m_st;
        if (flush) begin
            m_pc = '0; m_inst = NOP; m_valid = 1'b0;
            m_st = pc_enable ? 1 : 0;
`ifdef IF_ID_PERF_EN
            m_pb = sat(m_pb, 64'hFFFF_FFFF);
`endif
        end else if (!pc_enable) begin
            m_pc = '0; m_inst = NOP; m_valid = 1'b0; m_st = 0;
        end else begin
            if (stall[2]) begin
                // outputs frozen
            end else if (stall[1]) begin
                m_inst = NOP; m_valid = 1'b0;
`ifdef IF_ID_PERF_EN
                m_pb = sat(m_pb, 64'hFFFF_FFFF);
`endif
            end else begin
                m_pc = if_pc; m_inst = if_inst; m_valid = 1'b1;
`ifdef IF_ID_PERF_EN
                m_pi = sat(m_pi, 64'hFFFF_FFFF);
`endif
            end
            if (old_st == 0)                  m_st = 1;
            else if (old_st == 1 && stall[2]) m_st = 2;
            else if (old_st == 2 && !stall[2]) m_st = 1;
        end
`ifdef IF_ID_PERF_EN
        if (old_st == 2) m_ps = sat(m_ps, 64'hFFFF_FFFF);
`endif
        #1;
    endtask

    task automatic drive(input logic en, input logic fl, input logic [SW-1:0] st,
                         input logic [AW-1:0] pc, input logic [31:0] inst);
        pc_enable = en; flush = fl; stall = st; if_pc = pc; if_inst = inst;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 32'h0);
        model_reset();
        #12;
        total++; if (id_pc !== '0)     begin bad++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
        total++; if (id_inst !== NOP)  begin bad++; $display("FAIL reset_inst got=%h exp=%h", id_inst, NOP); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        // run with valid data, then drop reset between edges
        drive(1'b1, 1'b0, '0, 32'h40, 32'h1234_5678);
        tick(); tick();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b exp=1", id_valid); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (id_valid !== 1'b0 || id_pc !== '0 || id_inst !== NOP)
            begin bad++; $display("FAIL async_reset got=%h/%h/%b exp=0/%h/0", id_pc, id_inst, id_valid, NOP); end
        drive(1'b0, 1'b0, '0, '0, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", id_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] insts [3];
        insts[0] = 32'h2401_0001; insts[1] = 32'h2402_0002; insts[2] = 32'h0022_1820;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, '0, AW'(i*4), insts[i]);
            tick();
            total++; if (id_pc !== AW'(i*4) || id_inst !== insts[i] || id_valid !== 1'b1)
                begin bad++; $display("FAIL stream%0d got=%h/%h/%b exp=%h/%h/1", i, id_pc, id_inst, id_valid, i*4, insts[i]); end
        end
    endtask

    task automatic test_id_stall();
`ifdef IF_ID_PERF_EN
        longint ps0 = m_ps;
`endif
        drive(1'b1, 1'b0, '0, AW'(4), 32'h2402_0002);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, SW'(6'b000110), AW'(8), 32'h0022_1820);
            tick();
            total++; if (id_pc !== AW'(4) || id_inst !== 32'h2402_0002 || id_valid !== 1'b1)
                begin bad++; $display("FAIL stall_hold%0d got=%h/%h/%b exp=4/24020002/1", i, id_pc, id_inst, id_valid); end
        end
        drive(1'b1, 1'b0, '0, AW'(8), 32'h0022_1820);
        tick();
        total++; if (id_pc !== AW'(8) || id_inst !== 32'h0022_1820 || id_valid !== 1'b1)
            begin bad++; $display("FAIL stall_release got=%h/%h/%b exp=8/00221820/1", id_pc, id_inst, id_valid); end
`ifdef IF_ID_PERF_EN
        total++; if (perf_stall !== 32'(m_ps) || m_ps - ps0 != 3)
            begin bad++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall, ps0 + 3); end
`endif
    endtask

    task automatic test_bubble();
`ifdef IF_ID_PERF_EN
        longint pb0 = m_pb;
`endif
        drive(1'b1, 1'b0, SW'(6'b000010), AW'(12), 32'hDEAD_BEEF);
        tick();
        total++; if (id_pc !== AW'(8) || id_inst !== NOP || id_valid !== 1'b0)
            begin bad++; $display("FAIL bubble got=%h/%h/%b exp=8/%h/0", id_pc, id_inst, id_valid, NOP); end
`ifdef IF_ID_PERF_EN
        total++; if (perf_bubble !== 32'(pb0 + 1))
            begin bad++; $display("FAIL perf_bubble got=%0d exp=%0d", perf_bubble, pb0 + 1); end
`endif
        // ignored stall bits must not disturb a pass
        drive(1'b1, 1'b0, SW'(6'b111001), AW'(12), 32'hDEAD_BEEF);
        tick();
        total++; if (id_pc !== AW'(12) || id_inst !== 32'hDEAD_BEEF || id_valid !== 1'b1)
            begin bad++; $display("FAIL ignored_bits got=%h/%h/%b exp=c/deadbeef/1", id_pc, id_inst, id_valid); end
    endtask

    task automatic test_flush_vs_stall();
        drive(1'b1, 1'b0, '0, AW'(8), 32'h0022_1820);
        tick();
        drive(1'b1, 1'b0, SW'(6'b000110), AW'(12), 32'h1111_1111);
        tick();
        drive(1'b1, 1'b1, SW'(6'b000110), AW'(12), 32'h1111_1111);
        tick();
        total++; if (id_pc !== '0 || id_inst !== NOP || id_valid !== 1'b0)
            begin bad++; $display("FAIL flush_stall got=%h/%h/%b exp=0/%h/0", id_pc, id_inst, id_valid, NOP); end
        drive(1'b1, 1'b0, '0, AW'(16), 32'h2222_2222);
        tick();
        total++; if (id_pc !== AW'(16) || id_inst !== 32'h2222_2222 || id_valid !== 1'b1)
            begin bad++; $display("FAIL flush_run got=%h/%h/%b exp=10/22222222/1", id_pc, id_inst, id_valid); end
        drive(1'b0, 1'b0, '0, AW'(20), 32'h3333_3333);
        tick();
        total++; if (id_pc !== '0 || id_valid !== 1'b0)
            begin bad++; $display("FAIL pc_disable got=%h/%b exp=0/0", id_pc, id_valid); end
    endtask

    task automatic test_pc_wrap();
        logic [AW-1:0] top;
        top = '1;
        drive(1'b1, 1'b0, '0, top - AW'(3), 32'hAAAA_0001);
        tick();
        total++; if (id_pc !== top - AW'(3)) begin bad++; $display("FAIL wrap_hi got=%h exp=%h", id_pc, top - AW'(3)); end
        drive(1'b1, 1'b0, '0, top + AW'(1), 32'hAAAA_0002);
        tick();
        total++; if (id_pc !== '0 || id_inst !== 32'hAAAA_0002)
            begin bad++; $display("FAIL wrap_lo got=%h/%h exp=0/aaaa0002", id_pc, id_inst); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
                  SW'($urandom) & ($urandom_range(0, 2) == 0 ? SW'('1) : SW'(6'b111001)),
                  AW'($urandom), $urandom);
            tick();
            total++;
            if (id_pc !== m_pc || id_inst !== m_inst || id_valid !== m_valid) begin
                bad++; errs++;
                if (errs < 10)
                    $display("FAIL random%0d got=%h/%h/%b exp=%h/%h/%b", i, id_pc, id_inst, id_valid, m_pc, m_inst, m_valid);
            end
`ifdef IF_ID_PERF_EN
            total++;
            if (perf_inst !== 32'(m_pi) || perf_stall !== 32'(m_ps) || perf_bubble !== 32'(m_pb)) begin
                bad++; errs++;
                if (errs < 10)
                    $display("FAIL random_perf%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                             perf_inst, perf_stall, perf_bubble, m_pi, m_ps, m_pb);
            end
`endif
        end
    endtask

`ifdef IF_ID_PERF_EN
    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, '0, AW'(i*4), 32'h1000_0000 + i);
            tick();
        end
        total++; if (p4_inst !== 4'hF) begin bad++; $display("FAIL sat_inst got=%h exp=f", p4_inst); end
        total++; if (perf_inst !== 32'(m_pi)) begin bad++; $display("FAIL sat_wide got=%0d exp=%0d", perf_inst, m_pi); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_id_stall();
        test_bubble();
        test_flush_vs_stall();
        test_pc_wrap();
        test_random();
`ifdef IF_ID_PERF_EN
        test_saturation();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
